// File: rtl/pulse_burst_tx_pkg.sv
// Shared types and helpers for the pin-pulse transmitter.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 16;

  // Phase-timer width: enough bits to hold max(high_cyc, low_cyc) - 1.
  // Never narrower than one bit, so 1-cycle phases still get a legal vector.
  function automatic int timer_w(input int high_cyc, input int low_cyc);
    int m;
    m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_burst_tx_phase_timer.sv
// Loadable down-counter shared by the HIGH and LOW phases of the pulse FSM.
// o_expire is high while the count sits at zero, i.e. in the last cycle of a phase.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/pulse_burst_tx.sv
// Pin-pulse transmitter: accepts a count over valid/ready and emits that many
// fixed-width pulses on pulse_out, with abort and completion strobes.
//
// Handshake: a request is taken on a rising edge where req_valid and req_ready
// are both high; req_count is sampled only at that edge. req_ready is high
// whenever the FSM is IDLE, including the cycle that carries done, so a new
// burst can be queued back-to-back.
module pulse_burst_tx
  import pulse_tx_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulses_sent,
  output logic [1:0]       dbg_state
);

  localparam int TMR_W = timer_w(HIGH_CYC, LOW_CYC);
  localparam logic [TMR_W-1:0] HIGH_LD = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LD  = TMR_W'(LOW_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_pulses_sent;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;

  logic             w_handshake;
  logic             w_load;
  logic [TMR_W-1:0] w_load_val;
  logic             w_expire;

  assign w_handshake = req_valid & ~r_busy;

  // The timer is held at HIGH_LD while idle, so entering HIGH needs no extra
  // load; every phase end reloads it for whichever phase comes next.
  assign w_load     = (r_state == IDLE) | w_expire;
  assign w_load_val = (r_state == HIGH) ? LOW_LD : HIGH_LD;

  phase_timer #(
    .W(TMR_W)
  ) u_phase_timer (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  // Burst FSM with registered pin, status strobes and counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_pulses_sent <= '0;
      r_pulse_out   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        IDLE: begin
          // abort is deliberately not looked at here.
          if (w_handshake) begin
            if (req_count != '0) begin
              r_remaining   <= req_count;
              r_pulses_sent <= CNT_W'(1);
              r_pulse_out   <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= HIGH;
            end else begin
              r_pulses_sent <= '0;
              r_done        <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (abort) begin
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_aborted   <= 1'b1;
            r_state     <= IDLE;
          end else if (w_expire) begin
            r_pulse_out <= 1'b0;
            r_state     <= LOW;
          end
        end
        LOW: begin
          if (abort) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= IDLE;
          end else if (w_expire) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_pulse_out <= 1'b1;
              r_state     <= HIGH;
              if (r_pulses_sent != '1) begin
                r_pulses_sent <= r_pulses_sent + 1'b1;
              end
            end
          end
        end
        default: begin
          r_pulse_out <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign pulse_out   = r_pulse_out;
  assign busy        = r_busy;
  assign req_ready   = ~r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign pulses_sent = r_pulses_sent;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pulse_burst_tx.sv
// Bench for pulse_burst_tx: a vector table of bursts plus hand-written
// back-to-back, abort, reset and loopback sequences, checked by a scoreboard.
module tb_pulse_burst_tx;
  import pulse_tx_pkg::*;

  localparam int CNT_W = 16;
  localparam int HC    = 4;
  localparam int LC    = 4;
  localparam int PER   = HC + LC;
  localparam int NVEC  = 14;

  typedef struct packed {
    int pulses;
    int sent;
    bit aborted;
    int busy_cyc;
  } exp_t;

  typedef struct {
    int   n;
    int   k;   // busy-cycle index at which abort is sampled, -1 for none
    bit   hs;  // abort held high during the handshake edge
    exp_t e;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             req_valid;
  logic [CNT_W-1:0] req_count;
  logic             req_ready;
  logic             abort;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pulses_sent;
  logic [1:0]       dbg_state;

  always #5 sys_clk = ~sys_clk;

  pulse_burst_tx #(
    .CNT_W    (CNT_W),
    .HIGH_CYC (HC),
    .LOW_CYC  (LC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_count   (req_count),
    .req_ready   (req_ready),
    .abort       (abort),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pulses_sent (pulses_sent),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[NVEC];

  int busy_cnt     = 0;
  int burst_pulses = 0;
  int high_run     = 0;
  int low_run      = 0;
  int gap_cnt      = 0;
  int done_seen    = 0;
  int far_cnt      = 0;
  bit prev_pulse   = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int n, input int k);
    exp_t e;
    if (n == 0) begin
      e.pulses = 0; e.sent = 0; e.aborted = 1'b0; e.busy_cyc = 0;
    end else if (k < 0) begin
      e.pulses = n; e.sent = n; e.aborted = 1'b0; e.busy_cyc = n * PER;
    end else begin
      e.pulses = k / PER + 1; e.sent = k / PER + 1; e.aborted = 1'b1; e.busy_cyc = k + 1;
    end
    return e;
  endfunction

  function automatic vec_t mk(input int n, input int k, input bit hs,
                              input int p, input int s, input bit a, input int b);
    vec_t v;
    v.n = n; v.k = k; v.hs = hs;
    v.e.pulses = p; v.e.sent = s; v.e.aborted = a; v.e.busy_cyc = b;
    return v;
  endfunction

  // Far-end edge counter standing in for the pin counter on the other board.
  always @(posedge pulse_out) far_cnt++;

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      busy_cnt = 0; burst_pulses = 0; high_run = 0; low_run = 0;
      prev_pulse = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (pulse_out && !prev_pulse) begin
        if (burst_pulses > 0) chk("low_run_in_burst", low_run, LC);
        if (low_run == LC + 1) gap_cnt++;
        burst_pulses++;
      end
      if (!pulse_out && prev_pulse && !aborted) chk("high_run", high_run, HC);
      if (pulse_out) begin
        high_run = prev_pulse ? high_run + 1 : 1;
      end else begin
        low_run = prev_pulse ? 1 : low_run + 1;
      end
      prev_pulse = pulse_out;

      if (done) begin
        done_seen++;
        chk("ready_in_done_cycle", req_ready, 1);
        chk("done_state_idle", dbg_state, 0);
        chk("done_has_expectation", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("pulses_emitted", burst_pulses, mon_e.pulses);
          chk("pulses_sent", pulses_sent, mon_e.sent);
          chk("aborted_flag", aborted, mon_e.aborted);
          chk("busy_cycles", busy_cnt, mon_e.busy_cyc);
        end
        busy_cnt = 0;
        burst_pulses = 0;
      end else if (aborted) begin
        chk("aborted_without_done", aborted, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge with the DUT idle (or in its done cycle).
  task automatic send_req(input int n, input int k, input bit hs, input bit push, input exp_t e);
    if (push) exp_q.push_back(e);
    req_valid = 1'b1;
    req_count = CNT_W'(n);
    abort     = hs;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_valid = 1'b0;
    abort     = 1'b0;
    req_count = CNT_W'($urandom_range(0, 65535));
    if (n != 0) begin
      chk("first_high_latency", pulse_out, 1);
      chk("busy_after_hs", busy, 1);
    end else begin
      chk("zero_done", done, 1);
      chk("zero_no_pulse", pulse_out, 0);
    end
    if (k >= 0) begin
      repeat (k) @(negedge sys_clk);
      abort = 1'b1;
      @(negedge sys_clk);
      abort = 1'b0;
      chk("abort_pin_low", pulse_out, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk("done_within_budget", got, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   g0, d0, f0, n, k;
    exp_t e;
    sys_rst_n = 1'b0;
    req_valid = 1'b0;
    req_count = '0;
    abort     = 1'b0;
    #3;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_pulses_sent", pulses_sent, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    vecs[0] = mk(3, -1, 0, 3, 3, 0, 24);
    vecs[1] = mk(0, -1, 0, 0, 0, 0, 0);
    vecs[2] = mk(1, -1, 0, 1, 1, 0, 8);
    vecs[3] = mk(10, 25, 0, 4, 4, 1, 26);  // 2nd cycle of pulse 4's HIGH
    vecs[4] = mk(5, 4, 0, 1, 1, 1, 5);     // first LOW cycle
    vecs[5] = mk(2, 0, 0, 1, 1, 1, 1);     // first HIGH cycle
    vecs[6] = mk(2, -1, 1, 2, 2, 0, 16);   // abort with handshake is ignored
    vecs[7] = mk(4, 31, 0, 4, 4, 1, 32);   // abort on the final LOW cycle
    for (int i = 8; i < NVEC; i++) begin
      n = int'($urandom_range(1, 6));
      k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * PER - 1)) : -1;
      vecs[i].n = n; vecs[i].k = k; vecs[i].hs = 1'b0;
      vecs[i].e = model(n, k);
    end

    for (int i = 0; i < NVEC; i++) begin
      send_req(vecs[i].n, vecs[i].k, vecs[i].hs, 1'b1, vecs[i].e);
      wait_done(vecs[i].n * PER + 20);
      repeat (3) @(negedge sys_clk);
      chk("sent_holds_after_done", pulses_sent, vecs[i].e.sent);
      chk("idle_ready", req_ready, 1);
    end

    // Back-to-back: second request accepted in the done cycle.
    g0 = gap_cnt;
    send_req(2, -1, 1'b0, 1'b1, model(2, -1));
    wait_done(2 * PER + 20);
    send_req(1, -1, 1'b0, 1'b1, model(1, -1));
    wait_done(PER + 20);
    chk("b2b_gap_low_plus_one", gap_cnt - g0, 1);
    repeat (3) @(negedge sys_clk);

    // Abort while idle does nothing.
    d0 = done_seen;
    abort = 1'b1;
    repeat (3) @(negedge sys_clk);
    abort = 1'b0;
    @(negedge sys_clk);
    chk("idle_abort_no_done", done_seen - d0, 0);
    chk("idle_abort_not_busy", busy, 0);

    // Reset asserted between edges during a HIGH phase.
    e = model(5, -1);
    send_req(5, -1, 1'b0, 1'b0, e);
    repeat (9) @(negedge sys_clk);
    chk("pre_reset_high", pulse_out, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_pulse_out", pulse_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_pulses_sent", pulses_sent, 0);
    chk("mid_rst_done", done, 0);
    d0 = done_seen;
    repeat (2) @(negedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("no_done_after_reset", done_seen - d0, 0);
    chk("idle_after_reset", pulse_out, 0);

    // Loopback into the far-end edge counter.
    f0 = far_cnt;
    send_req(500, -1, 1'b0, 1'b1, model(500, -1));
    wait_done(500 * PER + 20);
    repeat (2) @(negedge sys_clk);
    chk("far_end_count", far_cnt - f0, 500);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
